// File: rtl/vector_exec_sequencer.sv
// vector_exec_sequencer: runs one decoded instruction over its element cycles,
// driving register-file, memory, accumulator and jump strobes; stalls issue until retire.
module vector_exec_sequencer #(
    parameter int NUM_ELEM = 16,
    parameter int ADDR_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        issue_valid,
    output logic                        issue_ready,
    input  logic [3:0]                  functype,
    input  logic [4:0]                  cycleCount,
    input  logic                        v_en,
    input  logic                        s_en,
    input  logic [2:0]                  dstAddr,
    input  logic [2:0]                  addr1,
    input  logic [2:0]                  addr2,
    input  logic [5:0]                  offset,
    input  logic [7:0]                  immediate,
    input  logic [ADDR_W-1:0]           base_data,
    output logic [$clog2(NUM_ELEM)-1:0] elem_idx,
    output logic [2:0]                  rd_addr1,
    output logic [2:0]                  rd_addr2,
    output logic                        vrf_we,
    output logic                        srf_we,
    output logic [2:0]                  wr_addr,
    output logic [7:0]                  imm_out,
    output logic                        imm_hi,
    output logic                        mem_re,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic                        acc_clr,
    output logic                        acc_en,
    output logic                        jump_valid,
    output logic [7:0]                  jump_target,
    output logic                        done
);
    localparam int EW = $clog2(NUM_ELEM);
    localparam logic [3:0] VADD = 4'd0, VDOT = 4'd1, SMUL = 4'd2, SST = 4'd3, VLD = 4'd4,
                           VST = 4'd5, SLL = 4'd6, SLH = 4'd7, J = 4'd8;

    typedef enum logic {IDLE, EXEC} state_t;
    state_t state, state_n;

    logic [3:0]        op;
    logic [4:0]        cnt;
    logic [EW:0]       elem, elem_w;
    logic [2:0]        dst, a1, a2;
    logic [5:0]        off;
    logic [7:0]        imm;
    logic [ADDR_W-1:0] base;
    logic              exec, last, accept, unused_en;

    assign exec        = state == EXEC;
    assign last        = cnt == 5'd0;
    assign issue_ready = !exec;
    assign accept      = issue_valid && issue_ready;
    assign unused_en   = v_en ^ s_en;

    always_comb begin
        state_n = state;
        if (!exec)
            state_n = (accept && functype <= J) ? EXEC : IDLE;
        else
            state_n = last ? IDLE : EXEC;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op    <= '0;
            cnt   <= '0;
            elem  <= '0;
            dst   <= '0;
            a1    <= '0;
            a2    <= '0;
            off   <= '0;
            imm   <= '0;
            base  <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                op   <= functype;
                cnt  <= cycleCount;
                elem <= '0;
                dst  <= dstAddr;
                a1   <= addr1;
                a2   <= addr2;
                off  <= offset;
                imm  <= immediate;
                base <= base_data;
            end else if (exec && !last) begin
                cnt  <= cnt - 5'd1;
                elem <= elem + (EW+1)'(1);
            end
        end
    end

    // VLD writes lag reads by one cycle, so elem_idx reports the element being written
    assign elem_w      = (op == VLD && elem != '0) ? elem - (EW+1)'(1) : elem;
    assign elem_idx    = exec ? elem_w[EW-1:0] : '0;
    assign rd_addr1    = exec ? a1 : '0;
    assign rd_addr2    = exec ? a2 : '0;
    assign wr_addr     = exec ? dst : '0;
    assign imm_out     = exec ? imm : '0;
    assign jump_target = exec ? imm : '0;
    assign vrf_we      = exec && (op == VADD || op == SMUL || (op == VLD && elem != '0));
    assign srf_we      = exec && ((op == VDOT && last) || op == SLL || op == SLH);
    assign imm_hi      = exec && op == SLH;
    assign mem_re      = exec && op == VLD && !elem[EW];
    assign mem_we      = exec && (op == VST || op == SST);
    assign mem_addr    = exec ? base + ADDR_W'($signed(off)) + ADDR_W'(elem) : '0;
    assign acc_clr     = exec && op == VDOT && elem == '0;
    assign acc_en      = exec && op == VDOT;
    assign jump_valid  = exec && op == J;
    assign done        = exec && last;
endmodule

// File: doc/vector_exec_sequencer.md
Name: vector_exec_sequencer

Overview:
- Sits directly downstream of the instruction decoder.
- Accepts one decoded instruction (functype, cycleCount, enables, register addresses, offset, immediate) and runs it over the required number of cycles.
- Per cycle it emits the element index, register-file read/write strobes, data-memory strobes and addresses, and the jump request.
- Holds fetch stalled (issue_ready low) until the instruction retires.

Parameters:
- NUM_ELEM, 16, vector length; element index width is log2(NUM_ELEM).
- ADDR_W, 16, data-memory address width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- issue_valid  in  1  decoded instruction present
- issue_ready  out  1  sequencer idle; instruction accepted when issue_valid && issue_ready
- functype  in  4  decoder opcode: 0 VADD, 1 VDOT, 2 SMUL, 3 SST, 4 VLD, 5 VST, 6 SLL, 7 SLH, 8 J, F NOP
- cycleCount  in  5  last element-cycle index from decoder (0, 15 or 16)
- v_en, s_en  in  1 each  vector / scalar writeback enables from decoder
- dstAddr, addr1, addr2  in  3 each  register addresses from decoder
- offset  in  6  memory offset, signed two's complement
- immediate  in  8  SLL/SLH/J immediate
- base_data  in  ADDR_W  scalar register value read at addr1, valid in the issue cycle
- elem_idx  out  4  current element
- rd_addr1, rd_addr2  out  3 each  latched read addresses
- vrf_we, srf_we  out  1 each  register-file write strobes
- wr_addr  out  3  latched dstAddr
- imm_out  out  8  latched immediate
- imm_hi  out  1  1 for SLH, 0 otherwise
- mem_re, mem_we  out  1 each  data-memory strobes
- mem_addr  out  ADDR_W  data-memory address
- acc_clr, acc_en  out  1 each  VDOT accumulator control
- jump_valid  out  1  one-cycle jump request
- jump_target  out  8  latched immediate
- done  out  1  one-cycle retire pulse

Behaviour:
- Reset (async, any state): state=IDLE, issue_ready=1, all other outputs 0.
- States: IDLE, EXEC.
- IDLE:
  - On accept: latch all fields and base_data, set cnt=cycleCount, elem=0.
  - Go to EXEC next cycle. If functype=NOP (or any undefined code), stay in IDLE, no outputs, no done.
- EXEC:
  - One element-cycle per clock; elem_idx=elem.
  - If cnt==0: assert done, return to IDLE (issue_ready=1 next cycle). Otherwise cnt-=1, elem+=1.
  - Total EXEC cycles = cycleCount+1. New instruction earliest the cycle after done; no overlap.
- Per-op outputs during EXEC:
  - VADD/SMUL: vrf_we=1 every cycle, wr_addr=dstAddr, elem_idx=element being written.
  - VDOT: acc_clr=1 in cycle 0; acc_en=1 all 16 cycles; srf_we=1 only in final cycle.
  - VLD (17 cycles, 1-cycle memory latency):
    - mem_re=1 for elem 0..15 in cycles 0..15.
    - vrf_we=1 in cycles 1..16, writing element elem-1; elem_idx reports the write element in those cycles.
    - Cycle 16: mem_re=0.
  - VST (16 cycles): mem_we=1 every cycle, rd_addr2 = source vector.
  - SST (1 cycle): mem_we=1, elem_idx=0.
  - SLL/SLH (1 cycle): srf_we=1, wr_addr=dstAddr, imm_out=immediate, imm_hi set for SLH.
  - J (1 cycle): jump_valid=1, jump_target=immediate.
- Address generation: mem_addr = base + sext(offset) + elem, modulo 2^ADDR_W (wraps, no overflow flag).
- Outputs are registered-state driven; strobes are 0 whenever state=IDLE.
- issue_valid while busy: ignored. Inputs may change freely during EXEC; only latched copies are used.
- Reset mid-operation: immediate abort, no further strobes, no done.

Test Plan:
- Reset then VADD (functype 0, cycleCount 15, dst 3, a1 1, a2 2) -> 16 cycles vrf_we=1, elem_idx 0..15, wr_addr=3; done at cycle 15; issue_ready=0 throughout EXEC.
- VLD with base_data=0x0100, offset=6'b111110 (-2) -> mem_re cycles 0..15, mem_addr 0x00FE..0x010D; vrf_we cycles 1..16 with elem_idx 0..15; done at cycle 16.
- VST with base 0xFFF8, offset 4 -> mem_addr 0xFFFC, 0xFFFD, 0xFFFE, 0xFFFF, 0x0000, … 0x000B (wrap); mem_we 16 cycles.
- VDOT -> acc_clr only cycle 0, acc_en 16 cycles, srf_we only cycle 15. Then back-to-back SLH imm 0xA5 -> one cycle srf_we=1, imm_out=0xA5, imm_hi=1.
- J imm 0x3C, then NOP, with issue_valid held high -> jump_valid one cycle, target 0x3C. NOP accepted with no strobes and no done. A third instruction offered during J's EXEC cycle is not accepted until issue_ready returns.
- Assert rst at cycle 7 of VST -> all outputs 0 asynchronously, issue_ready=1. A following SST executes normally in 1 cycle.
